// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with a two-entry skid buffer, synchronous flush
// and a saturating counter of items squashed by flush.
module pipe_skid_stage #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Occupancy,
  output logic [CNTW-1:0]  DropCnt
);

  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [CNTW-1:0]  drop_cnt_q, drop_cnt_d;
  logic             accept, take;
  logic [1:0]       dropped;

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                               input logic [1:0]      b);
    logic [CNTW:0] sum;
    sum = {1'b0, a} + {{(CNTW-1){1'b0}}, b};
    return sum[CNTW] ? {CNTW{1'b1}} : sum[CNTW-1:0];
  endfunction

  // Handshakes depend only on registered state, so ready/valid never see a
  // combinational path from the neighbouring stages.
  assign InReady   = ~skid_vld_q;
  assign OutValid  = main_vld_q;
  assign OutData   = main_data_q;
  assign Occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign DropCnt   = drop_cnt_q;

  assign accept  = InValid & ~skid_vld_q;
  assign take    = main_vld_q & OutReady;
  assign dropped = {1'b0, main_vld_q & ~take} + {1'b0, skid_vld_q} + {1'b0, accept};

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    drop_cnt_d  = drop_cnt_q;
    if (Flush) begin
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_data_d = '0;
      skid_data_d = '0;
      drop_cnt_d  = sat_add(drop_cnt_q, dropped);
    end else begin
      case ({skid_vld_q, main_vld_q})
        2'b00: begin
          if (accept) begin
            main_vld_d  = 1'b1;
            main_data_d = InData;
          end
        end
        2'b01: begin
          if (accept && take) begin
            main_data_d = InData;
          end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = InData;
          end else if (take) begin
            // Main data is zeroed on the way to empty so OutData reads 0.
            main_vld_d  = 1'b0;
            main_data_d = '0;
          end
        end
        2'b11: begin
          if (take) begin
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
            skid_data_d = '0;
          end
        end
        default: begin
          main_vld_d  = 1'b0;
          skid_vld_d  = 1'b0;
          main_data_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: an 8-bit-counter instance and a 2-bit-counter
// instance share stimulus and are compared against a queue-based model.
module tb_pipe_skid_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Flush = 1'b0;
  logic       InValid = 1'b0;
  logic       OutReady = 1'b0;
  logic [7:0] InData = 8'h00;
  logic       InReady, OutValid, InReady_s, OutValid_s;
  logic [7:0] OutData, OutData_s;
  logic [1:0] Occupancy, Occupancy_s;
  logic [7:0] DropCnt;
  logic [1:0] DropCnt_s;

  int checks = 0;
  int fails = 0;

  // Model: queue of held items plus both drop counters.
  logic [7:0] q[$];
  int cnt8 = 0;
  int cnt2 = 0;
  logic [7:0] taken[$];

  pipe_skid_stage #(.WIDTH(8), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .InData(InData), .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .Occupancy(Occupancy), .DropCnt(DropCnt));

  pipe_skid_stage #(.WIDTH(8), .CNTW(2)) dut_s (
    .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady_s),
    .InData(InData), .OutValid(OutValid_s), .OutReady(OutReady), .OutData(OutData_s),
    .Occupancy(Occupancy_s), .DropCnt(DropCnt_s));

  always #5 clk = ~clk;

  function automatic logic [33:0] act_vec();
    return {InReady, OutValid, OutData, Occupancy, DropCnt,
            InReady_s, OutValid_s, OutData_s, Occupancy_s, DropCnt_s};
  endfunction

  function automatic logic [33:0] exp_vec();
    logic       rdy, vld;
    logic [7:0] d;
    logic [1:0] occ;
    rdy = (q.size() < 2);
    vld = (q.size() > 0);
    d   = vld ? q[0] : 8'h00;
    occ = 2'(q.size());
    return {rdy, vld, d, occ, 8'(cnt8), rdy, vld, d, occ, 2'(cnt2)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0; InData = 8'h00;
    q.delete(); taken.delete(); cnt8 = 0; cnt2 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    int sz, dr;
    bit acc, tk;
    @(negedge clk);
    InValid = iv; InData = d; OutReady = ordy; Flush = fl;
    sz  = q.size();
    acc = iv && (sz < 2);
    tk  = ordy && (sz > 0);
    if (OutValid && ordy) taken.push_back(OutData);
    @(posedge clk);
    if (fl) begin
      dr = sz - (tk ? 1 : 0) + (acc ? 1 : 0);
      q.delete();
      cnt8 = (cnt8 + dr > 255) ? 255 : cnt8 + dr;
      cnt2 = (cnt2 + dr > 3) ? 3 : cnt2 + dr;
    end else begin
      if (tk) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({InReady, OutValid, OutData, Occupancy, DropCnt} !== {1'b1, 1'b0, 8'h00, 2'd0, 8'h00}) begin
      fails++;
      $display("FAIL reset_values got %h want %h",
               {InReady, OutValid, OutData, Occupancy, DropCnt}, {1'b1, 1'b0, 8'h00, 2'd0, 8'h00});
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      checks++;
      if ({OutValid, OutData, Occupancy, InReady} !== {1'b1, 8'(i), 2'd1, 1'b1}) begin
        fails++;
        $display("FAIL stream[%0d] got v=%b d=%h occ=%0d rdy=%b want v=1 d=%h occ=1 rdy=1",
                 i, OutValid, OutData, Occupancy, InReady, 8'(i));
      end
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (act_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL stream_drain got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want[3];
    want[0] = 8'hA1; want[1] = 8'hB2; want[2] = 8'hC3;
    do_reset();
    cycle(1'b1, want[0], 1'b0, 1'b0);
    checks++;
    if ({Occupancy, InReady} !== {2'd1, 1'b1}) begin
      fails++;
      $display("FAIL bp_one got occ=%0d rdy=%b want occ=1 rdy=1", Occupancy, InReady);
    end
    cycle(1'b1, want[1], 1'b0, 1'b0);
    checks++;
    if ({Occupancy, InReady, OutData} !== {2'd2, 1'b0, want[0]}) begin
      fails++;
      $display("FAIL bp_full got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=%h",
               Occupancy, InReady, OutData, want[0]);
    end
    cycle(1'b1, want[2], 1'b0, 1'b0);
    checks++;
    if ({Occupancy, InReady, OutData} !== {2'd2, 1'b0, want[0]}) begin
      fails++;
      $display("FAIL bp_hold got occ=%0d rdy=%b d=%h want occ=2 rdy=0 d=%h",
               Occupancy, InReady, OutData, want[0]);
    end
    cycle(1'b1, want[2], 1'b1, 1'b0);
    cycle(1'b1, want[2], 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (taken.size() != 3 || taken[0] !== want[0] || taken[1] !== want[1] || taken[2] !== want[2]) begin
      fails++;
      $display("FAIL bp_order got n=%0d want A1 B2 C3", taken.size());
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL bp_end got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if ({Occupancy, OutValid, OutData, InReady, DropCnt} !== {2'd0, 1'b0, 8'h00, 1'b1, 8'd2}) begin
      fails++;
      $display("FAIL flush_full got occ=%0d v=%b d=%h rdy=%b cnt=%0d want 0 0 00 1 2",
               Occupancy, OutValid, OutData, InReady, DropCnt);
    end
  endtask

  task automatic test_flush_busy();
    do_reset();
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b1, 8'h6B, 1'b1, 1'b1);
    checks++;
    if (taken.size() != 1 || taken[0] !== 8'h5A) begin
      fails++;
      $display("FAIL flush_busy_take got n=%0d want one item 5A", taken.size());
    end
    checks++;
    if ({Occupancy, OutValid, DropCnt} !== {2'd0, 1'b0, 8'd1}) begin
      fails++;
      $display("FAIL flush_busy_state got occ=%0d v=%b cnt=%0d want 0 0 1", Occupancy, OutValid, DropCnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] want_s[3];
    logic [7:0] want_w[3];
    want_s[0] = 2'd2; want_s[1] = 2'd3; want_s[2] = 2'd3;
    want_w[0] = 8'd2; want_w[1] = 8'd4; want_w[2] = 8'd6;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'(k * 2 + 1), 1'b0, 1'b0);
      cycle(1'b1, 8'(k * 2 + 2), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (DropCnt_s !== want_s[k] || DropCnt !== want_w[k]) begin
        fails++;
        $display("FAIL sat[%0d] got cnt2=%0d cnt8=%0d want cnt2=%0d cnt8=%0d",
                 k, DropCnt_s, DropCnt, want_s[k], want_w[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({InReady, OutValid, OutData, Occupancy, DropCnt} !== {1'b1, 1'b0, 8'h00, 2'd0, 8'h00}) begin
      fails++;
      $display("FAIL async_reset got %h want %h",
               {InReady, OutValid, OutData, Occupancy, DropCnt}, {1'b1, 1'b0, 8'h00, 2'd0, 8'h00});
    end
    q.delete(); taken.delete(); cnt8 = 0; cnt2 = 0;
    @(negedge clk);
    reset = 1'b0; InValid = 1'b0;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    checks++;
    if ({OutValid, OutData, Occupancy} !== {1'b1, 8'h77, 2'd1}) begin
      fails++;
      $display("FAIL post_reset got v=%b d=%h occ=%0d want 1 77 1", OutValid, OutData, Occupancy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0));
      checks++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_busy();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
